imem_loader: RTL and testbench

//  Boot-time writer for the single-cycle core's instruction memory. Takes a framed

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader_word_packer.sv | 44 ++++
 rtl/imem_loader.sv | 112 +++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package imem_loader_pkg;

  // Default IMEM word-address width, kept in step with the core's fetch side.
  localparam int IMEM_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_LO = 3'd1,
    LDR_LEN_HI = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_CSUM   = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERR    = 3'd6
  } ldr_state_t;

  // True while a frame is being received (LEN_LO through CSUM).
  function automatic logic in_frame(input ldr_state_t s);
    return s inside {LDR_LEN_LO, LDR_LEN_HI, LDR_DATA, LDR_CSUM};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the loader, bundled as one bus.
// master = host/IMEM side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = imem_loader_pkg::IMEM_ADDR_WIDTH
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs accepted payload bytes into little-endian 32-bit words and emits a
// one-cycle word_valid pulse the cycle after the 4th byte of each word.
module imem_loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  // Lane counter, partial word and completed-word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= '0;
      low_bytes  <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register here sampling
      // pre-edge values, so ordering inside the block cannot create races.
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
      end else if (byte_valid) begin
        lane <= lane + 2'd1;
        unique case (lane)
          2'd0: low_bytes[7:0]   <= byte_data;
          2'd1: low_bytes[15:8]  <= byte_data;
          2'd2: low_bytes[23:16] <= byte_data;
          2'd3: begin
            word       <= {byte_data, low_bytes};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length/payload/checksum frame, writes the payload
// into IMEM and releases the core from reset once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int          BYTES_W   = ADDR_WIDTH + 3;
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  ldr_state_t            state, state_next;
  logic                  accept, start_ok, len_too_big;
  logic [7:0]            len_lo, csum;
  logic [15:0]           len_word;
  logic [BYTES_W-1:0]    bytes_left;
  logic [ADDR_WIDTH-1:0] ptr, addr_q;

  assign accept      = bus.in_valid & bus.in_ready;
  assign start_ok    = start & ~in_frame(state);
  assign len_word    = {bus.in_data, len_lo};
  assign len_too_big = {1'b0, len_word} > MAX_WORDS;

  assign bus.in_ready = in_frame(state);
  assign busy         = in_frame(state);
  assign done         = (state == LDR_DONE);
  assign err          = (state == LDR_ERR);
  assign bus.imem_addr = addr_q;

  imem_loader_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (accept && (state == LDR_DATA)),
    .byte_data  (bus.in_data),
    .word_valid (bus.imem_we),
    .word       (bus.imem_wdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LDR_IDLE;
    else      state <= state_next;
  end

  // Next-state logic driven by start pulses, accepted bytes and frame checks.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      LDR_IDLE, LDR_DONE, LDR_ERR:
        if (start) state_next = LDR_LEN_LO;
      LDR_LEN_LO:
        if (accept) state_next = LDR_LEN_HI;
      LDR_LEN_HI:
        if (accept) begin
          if (len_word == 16'd0) state_next = LDR_CSUM;
          else if (len_too_big)  state_next = LDR_ERR;
          else                   state_next = LDR_DATA;
        end
      LDR_DATA:
        if (accept && bytes_left == BYTES_W'(1)) state_next = LDR_CSUM;
      LDR_CSUM:
        if (accept) state_next = (bus.in_data == csum) ? LDR_DONE : LDR_ERR;
      default: state_next = LDR_IDLE;
    endcase
  end

  // Length, byte countdown, checksum, write pointer and core reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo     <= '0;
      bytes_left <= '0;
      csum       <= '0;
      ptr        <= BASE_ADDR;
      addr_q     <= BASE_ADDR;
      core_rst   <= 1'b0;
    end else begin
      // Released only from the second DONE cycle on, and dropped on the same
      // edge a restart leaves DONE.
      core_rst <= (state == LDR_DONE) && (state_next == LDR_DONE);
      if (start_ok) begin
        csum       <= '0;
        bytes_left <= '0;
        ptr        <= BASE_ADDR;
      end else if (accept) begin
        if (state != LDR_CSUM) csum <= csum ^ bus.in_data;
        if (state == LDR_LEN_LO) len_lo <= bus.in_data;
        if (state == LDR_LEN_HI) bytes_left <= BYTES_W'({len_word, 2'b00});
        if (state == LDR_DATA) begin
          bytes_left <= bytes_left - BYTES_W'(1);
          // Last byte of a word: latch its address for next cycle's write.
          if (bytes_left[1:0] == 2'b01) begin
            addr_q <= ptr;
            ptr    <= ptr + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte, expected IMEM
// writes are queued as stimulus is built and matched when the DUT writes.
module tb_imem_loader;

  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_rst, busy, done, err;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] mem [0:(2**AW)-1];
  logic [31:0] snap [0:4];
  logic [AW-1:0] wptr;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every IMEM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("we_data", bus.imem_wdata, e.data);
      end
      mem[bus.imem_addr] = bus.imem_wdata;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte; with gaps, idle cycles (with stray start pulses) come first.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        start        = ($urandom_range(0, 2) == 0);
      end
    end
    @(negedge clk);
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Send LEN, payload bytes (queue expected words) and checksum.
  task automatic send_payload(input logic [7:0] pl[$], input logic [15:0] n,
                              input bit gaps, output logic [7:0] cs);
    logic [31:0] w;
    w  = '0;
    cs = n[7:0] ^ n[15:8];
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < pl.size(); i++) begin
      cs = cs ^ pl[i];
      w[8*(i%4) +: 8] = pl[i];
      if (i % 4 == 3) begin
        exp_q.push_back('{addr: wptr, data: w});
        last_addr = wptr;
        last_data = w;
        wptr++;
      end
      send_byte(pl[i], gaps);
    end
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input logic [15:0] n, input bit gaps,
                            input bit bad_cs, input bit expect_ok, input string name);
    logic [7:0] cs;
    pulse_start();
    wptr = '0;
    send_payload(pl, n, gaps, cs);
    if (bad_cs) cs = (cs == 8'h00) ? 8'hFF : 8'h00;
    send_byte(cs, gaps);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({name, "_done"}, 32'(done), 32'(expect_ok));
    check({name, "_err"}, 32'(err), 32'(!expect_ok));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, "_corerst_first"}, 32'(core_rst), 32'd0);
    @(negedge clk);
    check({name, "_corerst"}, 32'(core_rst), 32'(expect_ok));
    repeat (2) @(negedge clk);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_addr_hold"}, 32'(bus.imem_addr), 32'(last_addr));
    check({name, "_data_hold"}, bus.imem_wdata, last_data);
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] pl[$];
    logic [7:0] cs;

    good = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    last_addr = '0;
    last_data = '0;
    wptr = '0;

    // Reset held with in_valid high.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // Good two-word frame.
    send_frame(good, 16'd2, 1'b0, 1'b0, 1'b1, "good");
    check("good_mem0", mem[0], 32'h00100513);
    check("good_mem1", mem[1], 32'h00200593);

    // Same frame, checksum byte 0x00.
    send_frame(good, 16'd2, 1'b0, 1'b1, 1'b0, "badcs");

    // Empty image.
    pl.delete();
    send_frame(pl, 16'd0, 1'b0, 1'b0, 1'b1, "n0");

    // Oversized length: error straight after LEN_HI.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    @(negedge clk);
    check("big_err", 32'(err), 32'd1);
    check("big_ready", 32'(bus.in_ready), 32'd0);
    check("big_busy", 32'(busy), 32'd0);
    check("big_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("big_err_hold", 32'(err), 32'd1);
    check("big_core_rst", 32'(core_rst), 32'd0);

    // Five random words gap-free, then identical frame with gaps and stray starts.
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    send_frame(pl, 16'd5, 1'b0, 1'b0, 1'b1, "ref5");
    for (int i = 0; i < 5; i++) snap[i] = mem[i];
    for (int i = 0; i < 5; i++) mem[i] = 32'hDEAD_BEEF;
    send_frame(pl, 16'd5, 1'b1, 1'b0, 1'b1, "gap5");
    for (int i = 0; i < 5; i++) check($sformatf("gap_image%0d", i), mem[i], snap[i]);

    // Largest legal image fills IMEM exactly.
    pl.delete();
    for (int i = 0; i < 4 * (2 ** AW); i++) pl.push_back(8'($urandom));
    send_frame(pl, 16'(2 ** AW), 1'b0, 1'b0, 1'b1, "full");
    check("full_last", mem[(2**AW)-1], last_data);

    // Reset after 6 payload bytes: word 0 written, everything else reset.
    pulse_start();
    wptr = '0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back('{addr: AW'(0), data: 32'h00100513});
    for (int i = 0; i < 6; i++) send_byte(good[i], 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(bus.in_ready), 32'd0);
    check("mid_we", 32'(bus.imem_we), 32'd0);
    check("mid_addr", 32'(bus.imem_addr), 32'd0);
    check("mid_wdata", bus.imem_wdata, 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_core_rst", 32'(core_rst), 32'd0);
    check("mid_word0", mem[0], 32'h00100513);
    check("mid_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_addr = '0;
    last_data = '0;
    @(negedge clk);
    check("mid_idle_ready", 32'(bus.in_ready), 32'd0);
    send_frame(good, 16'd2, 1'b0, 1'b0, 1'b1, "after_rst");
    check("after_rst_mem1", mem[1], 32'h00200593);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
